pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the parameter WDOG_LIMIT, default 8'd255, giving the consecutive-stall cycle count that trips the watchdog.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port stallreq_if, input, 1 bit: fetch-stage stall request.
REQ-005 The block SHALL have port stallreq_id, input, 1 bit: decode-stage stall request.
REQ-006 The block SHALL have port stallreq_ex, input, 1 bit: execute-stage stall request.
REQ-007 The block SHALL have port stallreq_mem, input, 1 bit: memory-stage stall request.
REQ-008 The block SHALL have port excp_req, input, 1 bit: exception raised by the memory stage.
REQ-009 The block SHALL have port excp_vector, input, 32 bits: handler address, valid with excp_req.
REQ-010 The block SHALL have port eret_req, input, 1 bit: exception-return request.
REQ-011 The block SHALL have port epc_in, input, 32 bits: return address, valid with eret_req.
REQ-012 The block SHALL have port stall, output, 6 bits: per-stage hold; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-013 The block SHALL have port flush, output, 1 bit: clear all pipeline registers.
REQ-014 The block SHALL have port new_pc, output, 32 bits: redirect target, valid while flush=1.
REQ-015 The block SHALL have port wdog_timeout, output, 1 bit: sticky stall-watchdog flag.

Function
REQ-016 The FSM SHALL have states RUN, FLUSH and DRAIN, and SHALL be in RUN after reset.
REQ-017 In RUN and DRAIN, stall SHALL be combinational, priority mem > ex > id > if: stallreq_mem gives 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-018 In FLUSH, stall SHALL be 6'b000000 regardless of requests.
REQ-019 In RUN, excp_req=1 SHALL latch excp_vector into new_pc and move to FLUSH on the next edge.
REQ-020 In RUN, eret_req=1 with excp_req=0 SHALL latch epc_in into new_pc and move to FLUSH.
REQ-021 When excp_req and eret_req are both 1, excp_req SHALL win and eret_req SHALL be dropped.
REQ-022 excp_req and eret_req SHALL take effect in RUN even when a stall request is active in the same cycle.
REQ-023 flush SHALL be 1 only in FLUSH, which lasts exactly one cycle; the next state SHALL be DRAIN.
REQ-024 DRAIN SHALL last exactly one cycle and then return to RUN.
REQ-025 excp_req and eret_req SHALL be ignored (not queued) in FLUSH and DRAIN.
REQ-026 new_pc SHALL hold its last latched value outside FLUSH.
REQ-027 Request-to-flush latency SHALL be 1 cycle; a request-to-next-accepted-request gap SHALL be at least 3 cycles.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set state=RUN, flush=0, new_pc=32'h00000000, wdog_timeout=0 and the watchdog counter to 0.
REQ-029 While rst=1, stall SHALL be forced to 6'b000000.
REQ-030 A reset in FLUSH or DRAIN SHALL abort the redirect, with no flush pulse after reset.

Configuration
REQ-031 With macro STALL_WATCHDOG_EN defined, an 8-bit counter SHALL increment each RUN/DRAIN cycle with stall!=0, clear on any cycle with stall=0 or in FLUSH, and saturate at WDOG_LIMIT.
REQ-032 With STALL_WATCHDOG_EN defined, wdog_timeout SHALL be set on the edge where the counter reaches WDOG_LIMIT and stay 1 until reset; stall behaviour SHALL be unchanged.
REQ-033 Without STALL_WATCHDOG_EN, the counter SHALL be absent and wdog_timeout SHALL be constant 0.

Verification
REQ-034 The bench SHALL check: rst=1 for 2 cycles, then rst=0 with no requests -> stall=0, flush=0, new_pc=0, wdog_timeout=0.
REQ-035 The bench SHALL check: stallreq_if=1 and stallreq_ex=1 together -> stall=6'b001111 in the same cycle; with stallreq_mem also 1 -> 6'b011111.
REQ-036 The bench SHALL check: in RUN, excp_req=1 with excp_vector=32'h00000020 and eret_req=1 with epc_in=32'h00000400 -> next cycle flush=1, new_pc=32'h00000020, stall=0; then DRAIN, then RUN.
REQ-037 The bench SHALL check: eret_req=1, epc_in=32'h00001004, then excp_req=1 held in the FLUSH and DRAIN cycles -> exactly one flush pulse with new_pc=32'h00001004, and the exception is not taken.
REQ-038 The bench SHALL check, with STALL_WATCHDOG_EN and WDOG_LIMIT=8'd4: stallreq_id held for 4 cycles -> wdog_timeout=1 after the 4th edge and still 1 after the request drops; with 3 cycles -> wdog_timeout stays 0.
REQ-039 The bench SHALL check: rst=1 asserted in the FLUSH cycle -> next cycle flush=0, state RUN, new_pc=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : pipe_ctrl
// Description : Pipeline stall/flush controller with exception/ERET redirect.
//               The optional stall watchdog is enabled by the macro
//               STALL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module pipe_ctrl #(
    parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_req,
    input  logic [31:0] excp_vector,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_timeout
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_new_pc;
    logic [31:0] w_new_pc_nxt;
    logic [5:0]  w_stall_req;
    logic [5:0]  w_stall;

    // The oldest stalling stage holds itself and everything upstream of it.
    always_comb begin
        w_stall_req = 6'b000000;
        if (stallreq_mem) begin
            w_stall_req = 6'b011111;
        end else if (stallreq_ex) begin
            w_stall_req = 6'b001111;
        end else if (stallreq_id) begin
            w_stall_req = 6'b000111;
        end else if (stallreq_if) begin
            w_stall_req = 6'b000011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_new_pc <= 32'h0000_0000;
        end else begin
            r_state  <= w_state_nxt;
            r_new_pc <= w_new_pc_nxt;
        end
    end

    // Redirects are only accepted in RUN, so a request arriving during the
    // FLUSH/DRAIN window is dropped rather than queued.
    always_comb begin
        w_state_nxt  = r_state;
        w_new_pc_nxt = r_new_pc;
        w_stall      = 6'b000000;
        flush        = 1'b0;
        case (r_state)
            RUN: begin
                w_stall = w_stall_req;
                if (excp_req) begin
                    w_new_pc_nxt = excp_vector;
                    w_state_nxt  = FLUSH;
                end else if (eret_req) begin
                    w_new_pc_nxt = epc_in;
                    w_state_nxt  = FLUSH;
                end
            end
            FLUSH: begin
                flush       = 1'b1;
                w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_stall     = w_stall_req;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign stall  = rst ? 6'b000000 : w_stall;
    assign new_pc = r_new_pc;

`ifdef STALL_WATCHDOG_EN
    logic [7:0] r_wdog_cnt;
    logic       r_wdog_timeout;

    // w_stall is already zero in FLUSH, so one test covers both clear cases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt     <= 8'd0;
            r_wdog_timeout <= 1'b0;
        end else if (w_stall == 6'b000000) begin
            r_wdog_cnt <= 8'd0;
        end else if (r_wdog_cnt != WDOG_LIMIT) begin
            r_wdog_cnt <= r_wdog_cnt + 8'd1;
            if (r_wdog_cnt + 8'd1 == WDOG_LIMIT) begin
                r_wdog_timeout <= 1'b1;
            end
        end
    end

    assign wdog_timeout = r_wdog_timeout;
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^WDOG_LIMIT;
    assign wdog_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl; redirect targets are
//               scoreboarded and compared whenever a flush pulse appears.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_req, eret_req;
    logic [31:0] excp_vector, epc_in;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdog_timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];

    pipe_ctrl #(.WDOG_LIMIT(8'd4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_req     (excp_req),
        .excp_vector  (excp_vector),
        .eret_req     (eret_req),
        .epc_in       (epc_in),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .wdog_timeout (wdog_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_reqs(input logic [3:0] r);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
    endtask

    // Every flush pulse consumes one expected redirect target.
    always @(negedge clk) begin
        if (flush === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("flush_unexpected", 32'd1, 32'd0);
            end else begin
                check("flush_new_pc", new_pc, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [3:0] pat_req [5] = '{4'b0101, 4'b1101, 4'b0010, 4'b0001, 4'b0000};
    logic [5:0] pat_exp [5] = '{6'b001111, 6'b011111, 6'b000111, 6'b000011, 6'b000000};

    initial begin
        rst = 1'b1;
        set_reqs(4'b1000);
        excp_req = 1'b0; eret_req = 1'b0;
        excp_vector = 32'h0; epc_in = 32'h0;

        // Reset: two cycles, stall forced low while rst is high
        step();
        mid();
        check("rst_stall_forced", {26'd0, stall}, 32'd0);
        step();
        rst = 1'b0;
        set_reqs(4'b0000);
        mid();
        check("rst_stall", {26'd0, stall}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_new_pc", new_pc, 32'd0);
        check("rst_wdog", {31'd0, wdog_timeout}, 32'd0);

        // Stall priority, checked in the cycle the requests are driven
        for (int i = 0; i < 5; i++) begin
            step();
            set_reqs(pat_req[i]);
            mid();
            check($sformatf("stall_pat%0d", i), {26'd0, stall}, {26'd0, pat_exp[i]});
            step();
            set_reqs(4'b0000);
        end

        // Exception wins over simultaneous ERET
        step();
        excp_req = 1'b1; excp_vector = 32'h0000_0020;
        eret_req = 1'b1; epc_in      = 32'h0000_0400;
        sb_q.push_back(32'h0000_0020);
        mid();
        step();
        excp_req = 1'b0; eret_req = 1'b0;
        set_reqs(4'b1000);
        mid();
        check("excp_flush", {31'd0, flush}, 32'd1);
        check("excp_flush_stall", {26'd0, stall}, 32'd0);
        step();
        mid();
        check("excp_drain_flush", {31'd0, flush}, 32'd0);
        check("excp_drain_stall", {26'd0, stall}, 32'h1f);

        // ERET accepted; exception held through FLUSH and DRAIN is dropped
        step();
        set_reqs(4'b0000);
        eret_req = 1'b1; epc_in = 32'h0000_1004;
        sb_q.push_back(32'h0000_1004);
        mid();
        check("eret_run_flush", {31'd0, flush}, 32'd0);
        step();
        eret_req = 1'b0;
        excp_req = 1'b1; excp_vector = 32'hdead_0000;
        mid();
        check("eret_flush", {31'd0, flush}, 32'd1);
        step();
        mid();
        check("eret_drain_flush", {31'd0, flush}, 32'd0);
        step();
        excp_req = 1'b0;
        mid();
        check("eret_no_second_flush", {31'd0, flush}, 32'd0);
        check("eret_pc_held", new_pc, 32'h0000_1004);
        step();
        mid();
        check("eret_no_late_flush", {31'd0, flush}, 32'd0);

        // Reset during FLUSH aborts the redirect
        step();
        excp_req = 1'b1; excp_vector = 32'h0000_0080;
        sb_q.push_back(32'h0000_0080);
        mid();
        step();
        excp_req = 1'b0;
        rst = 1'b1;
        mid();
        check("rstflush_pulse", {31'd0, flush}, 32'd1);
        step();
        rst = 1'b0;
        mid();
        check("rstflush_flush", {31'd0, flush}, 32'd0);
        check("rstflush_new_pc", new_pc, 32'd0);
        check("rstflush_stall", {26'd0, stall}, 32'd0);
        step();
        eret_req = 1'b1; epc_in = 32'h0000_0044;
        sb_q.push_back(32'h0000_0044);
        mid();
        step();
        eret_req = 1'b0;
        mid();
        check("rstflush_run_redirect", {31'd0, flush}, 32'd1);
        step();
        step();

        // Watchdog: 3 stall cycles stay below the limit, 4 trip it
        step();
        stallreq_id = 1'b1;
        step();
        step();
        step();
        stallreq_id = 1'b0;
        mid();
        check("wdog_3cyc", {31'd0, wdog_timeout}, 32'd0);
        step();
        mid();
        check("wdog_3cyc_after", {31'd0, wdog_timeout}, 32'd0);
        step();
        stallreq_id = 1'b1;
        step();
        step();
        step();
        step();
`ifdef STALL_WATCHDOG_EN
        check("wdog_4cyc", {31'd0, wdog_timeout}, 32'd1);
`else
        check("wdog_4cyc_disabled", {31'd0, wdog_timeout}, 32'd0);
`endif
        stallreq_id = 1'b0;
        step();
        mid();
`ifdef STALL_WATCHDOG_EN
        check("wdog_sticky", {31'd0, wdog_timeout}, 32'd1);
`else
        check("wdog_sticky_disabled", {31'd0, wdog_timeout}, 32'd0);
`endif
        check("wdog_stall_clear", {26'd0, stall}, 32'd0);

        step();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
